// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet generator: FSM states,
// LFSR tap table, header packing/slicing and payload mode encodings.
package router_pkg;

  localparam int unsigned PKT_COUNT_W = 16;

  localparam logic MODE_INC  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } state_t;

  // Galois right-shift tap masks (maximal-length where listed)
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      12:      return 32'h0000_0E08;
      16:      return 32'h0000_B400;
      default: return (32'd1 << (width - 1)) | 32'd1;
    endcase
  endfunction

  function automatic logic [31:0] make_header(input logic [31:0] len,
                                              input logic [31:0] addr,
                                              input int unsigned addr_w);
    return (len << addr_w) | (addr & ((32'd1 << addr_w) - 32'd1));
  endfunction

  function automatic logic [31:0] hdr_addr(input logic [31:0] hdr,
                                           input int unsigned addr_w);
    return hdr & ((32'd1 << addr_w) - 32'd1);
  endfunction

  function automatic logic [31:0] hdr_len(input logic [31:0] hdr,
                                          input int unsigned addr_w);
    return hdr >> addr_w;
  endfunction

endpackage

// File: rtl/router_pkt_gen_if.sv
// Control and router-side bus of the packet generator.
interface router_pkt_gen_if
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
);
  localparam int unsigned LEN_W = DATA_WIDTH - ADDR_WIDTH;

  logic                   start;
  logic [ADDR_WIDTH-1:0]  dest_addr;
  logic [LEN_W-1:0]       payload_len;
  logic                   mode;
  logic                   inject_err;
  logic                   busy;
  logic                   pkt_valid;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   gen_busy;
  logic                   done;
  logic                   addr_err;
  logic [PKT_COUNT_W-1:0] pkt_count;

  modport master (
    input  start, dest_addr, payload_len, mode, inject_err, busy,
    output pkt_valid, data_out, gen_busy, done, addr_err, pkt_count
  );

  modport slave (
    output start, dest_addr, payload_len, mode, inject_err, busy,
    input  pkt_valid, data_out, gen_busy, done, addr_err, pkt_count
  );
endinterface

// File: rtl/router_lfsr.sv
// Galois LFSR used as the pseudo-random payload source; advances on step.
module router_lfsr
  import router_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'hA5)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             step,
  output logic [WIDTH-1:0] value
);
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  if (SEED == '0) begin : g_seed_err
    $error("router_lfsr: SEED must be non-zero");
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      value <= SEED;
    end else if (step) begin
      value <= value[0] ? ((value >> 1) ^ TAPS) : (value >> 1);
    end
  end
endmodule

// File: rtl/router_pkt_gen.sv
// Header/payload/parity packet source for the 1xN router with busy
// back-pressure, parity-error injection and destination checking.
module router_pkt_gen
  import router_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 2,
  parameter int unsigned           NUM_CHAN   = 3,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED  = DATA_WIDTH'(8'hA5),
  parameter int unsigned           GAP_CYCLES = 2
) (
  input logic               clock,
  input logic               resetn,
  router_pkt_gen_if.master  bus
);
  localparam int unsigned LEN_W = DATA_WIDTH - ADDR_WIDTH;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ADDR_WIDTH:0] NUM_CHAN_L = (ADDR_WIDTH + 1)'(NUM_CHAN);

  if (ADDR_WIDTH >= DATA_WIDTH || NUM_CHAN > (1 << ADDR_WIDTH)) begin : g_param_err
    $error("router_pkt_gen: need ADDR_WIDTH < DATA_WIDTH and NUM_CHAN <= 2**ADDR_WIDTH");
  end

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_W-1:0]      len_q;
  logic                  mode_q;
  logic                  err_q;
  logic [LEN_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] parity;
  logic [GAP_W-1:0]      gap_cnt;

  logic                  accept;
  logic [LEN_W-1:0]      last_idx;
  logic [DATA_WIDTH-1:0] hdr;
  logic [DATA_WIDTH-1:0] parity_nxt;
  logic [DATA_WIDTH-1:0] err_word;
  logic [DATA_WIDTH-1:0] lfsr_value;
  logic                  lfsr_step;

  assign accept     = !bus.busy;
  assign last_idx   = len_q - LEN_W'(1);
  assign hdr        = DATA_WIDTH'(make_header(32'(bus.payload_len), 32'(bus.dest_addr), ADDR_WIDTH));
  assign parity_nxt = parity ^ bus.data_out;
  assign err_word   = DATA_WIDTH'(err_q);

  // The LFSR always holds the next payload byte, so it steps when a byte is
  // loaded into data_out, i.e. when the preceding byte is accepted.
  always_comb begin
    lfsr_step = 1'b0;
    if (accept && mode_q == MODE_LFSR) begin
      if (state == HEADER && len_q != '0) lfsr_step = 1'b1;
      if (state == PAYLOAD && cnt != last_idx) lfsr_step = 1'b1;
    end
  end

  router_lfsr #(
    .WIDTH (DATA_WIDTH),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clock  (clock),
    .resetn (resetn),
    .step   (lfsr_step),
    .value  (lfsr_value)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      mode_q        <= MODE_INC;
      err_q         <= 1'b0;
      cnt           <= '0;
      parity        <= '0;
      gap_cnt       <= '0;
      bus.pkt_valid <= 1'b0;
      bus.data_out  <= '0;
      bus.gen_busy  <= 1'b0;
      bus.done      <= 1'b0;
      bus.addr_err  <= 1'b0;
      bus.pkt_count <= '0;
    end else begin
      bus.done     <= 1'b0;
      bus.addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if ((ADDR_WIDTH + 1)'(bus.dest_addr) >= NUM_CHAN_L) begin
              bus.addr_err <= 1'b1;
            end else begin
              addr_q        <= bus.dest_addr;
              len_q         <= bus.payload_len;
              mode_q        <= bus.mode;
              err_q         <= bus.inject_err;
              parity        <= hdr;
              bus.data_out  <= hdr;
              bus.pkt_valid <= 1'b1;
              bus.gen_busy  <= 1'b1;
              state         <= HEADER;
            end
          end
        end
        HEADER: begin
          if (accept) begin
            cnt <= '0;
            if (len_q == '0) begin
              bus.pkt_valid <= 1'b0;
              bus.data_out  <= parity ^ err_word;
              state         <= PARITY;
            end else begin
              bus.data_out <= (mode_q == MODE_LFSR) ? lfsr_value : '0;
              state        <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (accept) begin
            parity <= parity_nxt;
            if (cnt == last_idx) begin
              bus.pkt_valid <= 1'b0;
              bus.data_out  <= parity_nxt ^ err_word;
              state         <= PARITY;
            end else begin
              cnt          <= cnt + LEN_W'(1);
              bus.data_out <= (mode_q == MODE_LFSR) ? lfsr_value
                                                    : DATA_WIDTH'(cnt + LEN_W'(1));
            end
          end
        end
        PARITY: begin
          if (accept) begin
            bus.data_out <= '0;
            gap_cnt      <= '0;
            if (GAP_CYCLES == 0) begin
              bus.done      <= 1'b1;
              bus.gen_busy  <= 1'b0;
              bus.pkt_count <= bus.pkt_count + PKT_COUNT_W'(1);
              state         <= IDLE;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (int'(gap_cnt) == int'(GAP_CYCLES) - 1) begin
            bus.done      <= 1'b1;
            bus.gen_busy  <= 1'b0;
            bus.pkt_count <= bus.pkt_count + PKT_COUNT_W'(1);
            state         <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Latched destination is kept for debug visibility of the active packet.
  logic unused_addr;
  assign unused_addr = ^addr_q;
endmodule

// File: doc/router_pkt_gen.md
Name: router_pkt_gen

Overview:
- Synthesizable, parametrised packet source for the 1xN router.
- Produces header / payload / parity packets on the router input bus and honours the router's busy back-pressure.
- Sits in front of router_top as an on-chip traffic generator and BIST source.
- Generalises the hand-written bench packet tasks:
  - configurable data width, address width and channel count;
  - payload modes;
  - parity-error injection;
  - address checking.

Parameters:
- DATA_WIDTH, 8, width of data bus and of every packet byte.
- ADDR_WIDTH, 2, width of destination-address field in header bits [ADDR_WIDTH-1:0].
- NUM_CHAN, 3, number of legal destinations (addresses 0..NUM_CHAN-1).
- LFSR_SEED, 8'hA5, non-zero LFSR reset/reload value (DATA_WIDTH bits).
- GAP_CYCLES, 2, idle cycles inserted after the parity byte before done.

Ports:
- clock, input, 1, system clock, rising edge.
- resetn, input, 1, asynchronous active-low reset.
- start, input, 1, request one packet; sampled only in IDLE.
- dest_addr, input, ADDR_WIDTH, destination; latched with start.
- payload_len, input, DATA_WIDTH-ADDR_WIDTH, payload byte count; latched with start.
- mode, input, 1, 0 = incrementing payload from 0, 1 = LFSR payload.
- inject_err, input, 1, invert parity bit 0; latched with start.
- busy, input, 1, router back-pressure.
- pkt_valid, output, 1, high while header/payload bytes are driven.
- data_out, output, DATA_WIDTH, packet byte to router data_in.
- gen_busy, output, 1, high from start acceptance until done.
- done, output, 1, one-cycle pulse at packet completion.
- addr_err, output, 1, one-cycle pulse when start has dest_addr >= NUM_CHAN.
- pkt_count, output, 16, packets completed since reset; wraps at 16'hFFFF -> 0.

Behaviour:
- All outputs are registered.
- Reset values:
  - pkt_valid = 0, data_out = 0, gen_busy = 0, done = 0, addr_err = 0, pkt_count = 0;
  - LFSR = LFSR_SEED;
  - state = IDLE.
- Reset is asynchronous and active-low. Reset mid-packet aborts immediately: no parity byte, no done, pkt_count unchanged.
- FSM states: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - start=1 with legal address: latch inputs; go to HEADER next edge. Header appears on data_out with pkt_valid=1 one cycle after start is sampled.
  - start=1 with illegal address: addr_err pulses the next cycle; stay in IDLE; pkt_valid stays 0.
- HEADER:
  - data_out = {payload_len, dest_addr}; parity accumulator = header.
  - Advance when busy=0 at the edge.
  - payload_len = 0 goes directly to PARITY.
- PAYLOAD:
  - Drive byte k (k = 0..len-1), k counted by a payload counter.
  - mode 0: data_out = k[DATA_WIDTH-1:0].
  - mode 1: data_out = current LFSR value; the LFSR steps only on an accepted byte.
  - XOR each accepted byte into parity.
  - After byte len-1 is accepted, go to PARITY.
- Back-pressure:
  - A byte is accepted at a rising edge with busy=0.
  - While busy=1, data_out, pkt_valid, the counter and the LFSR hold.
  - busy asserted in IDLE or GAP has no effect.
- PARITY:
  - pkt_valid = 0; data_out = parity ^ {{DATA_WIDTH-1{1'b0}}, inject_err_q}.
  - Held while busy=1; on acceptance go to GAP.
- GAP:
  - data_out = 0 for GAP_CYCLES cycles.
  - Then done pulses for one cycle, pkt_count increments, gen_busy drops, and the state returns to IDLE in the same cycle.
  - GAP_CYCLES = 0: done is asserted in the cycle following parity acceptance.
- start asserted outside IDLE is ignored (not queued).
- The LFSR is not reloaded between packets; it is reloaded only by reset.
- LFSR: Galois, polynomial x^8+x^6+x^5+x^4+1 for DATA_WIDTH = 8; taps for other widths come from the package.
- Elaboration check: ADDR_WIDTH < DATA_WIDTH and NUM_CHAN <= 2**ADDR_WIDTH.

Decomposition:
- router_pkg:
  - FSM state enum;
  - LFSR tap-mask table indexed by width;
  - header field-slice helper functions;
  - mode encoding constants.
- One sub-module, router_lfsr:
  - parameters WIDTH and SEED;
  - inputs clock, resetn, step;
  - output value.
- FSM, counter and parity stay in router_pkt_gen.

Test Plan:
- Incrementing-payload packet:
  - Stimulus: start, addr=2, len=14, mode 0, no busy.
  - Response: header 8'h3A, payload 0..13, parity 8'h3B with pkt_valid=0, done after 2 gap cycles, pkt_count=1.
- Back-to-back packet, second packet of the run:
  - Stimulus: addr=2, len=16, mode 0.
  - Response: header 8'h42, payload 0..15, parity 8'h42, pkt_count=2.
- Stall during payload:
  - Stimulus: busy=1 for 3 cycles while payload byte 5 is driven.
  - Response: data_out holds 8'h05 for 4 cycles total, then 8'h06; parity unaffected.
- Empty packet with error injection:
  - Stimulus: len=0, addr=1, inject_err=1.
  - Response: header 8'h01, parity 8'h00 (8'h01 with bit 0 inverted).
- Illegal address:
  - Stimulus: addr=3 with NUM_CHAN=3.
  - Response: single-cycle addr_err, pkt_valid stays 0, gen_busy stays 0, pkt_count unchanged.
- Reset mid-packet:
  - Stimulus: resetn low during LFSR-mode payload byte 4.
  - Response: all outputs 0 asynchronously. The next LFSR packet's first payload byte is 8'hA5.
